uart_transmitter: RTL

- 8N1 UART transmitter; the transmit-side counterpart of the system's UART receiver.
- Serialises one byte per request onto UART_TX: 1 start bit (0), 8 data bits LSB first, 1 stop bit (1).
- Bit timing comes from an internal divider on sysclk; no external baud clock.
- Driven by the CPU peripheral/bus logic through a start/busy/done handshake.

---
 rtl/uart_transmitter_if.sv | 38 +++
 rtl/uart_transmitter.sv | 131 +++++++++++++
 2 files changed

// File: rtl/uart_transmitter_if.sv
// ---------------------------------------------------------------------------
// uart_transmitter_if
//   Handshake bundle between the CPU peripheral logic and the UART transmitter.
//
//   Signals:
//     tx_start  request to send tx_data (level, sampled only while idle)
//     tx_data   byte to send, captured on the accepting edge
//     UART_TX   serial line, idles high
//     tx_busy   frame in flight
//     tx_done   one-cycle pulse at the end of a frame
//
//   Modports:
//     master  bus / CPU side (drives the request)
//     slave   transmitter side (drives the line and status)
// ---------------------------------------------------------------------------
interface uart_transmitter_if;
    logic       tx_start;
    logic [7:0] tx_data;
    logic       UART_TX;
    logic       tx_busy;
    logic       tx_done;

    modport master (
        output tx_start,
        output tx_data,
        input  UART_TX,
        input  tx_busy,
        input  tx_done
    );

    modport slave (
        input  tx_start,
        input  tx_data,
        output UART_TX,
        output tx_busy,
        output tx_done
    );
endinterface

// File: rtl/uart_transmitter.sv
// ---------------------------------------------------------------------------
// uart_transmitter
//   8N1 UART transmitter: 1 start bit (0), 8 data bits LSB first, 1 stop bit
//   (1). Bit timing is derived from sysclk by an internal divider of
//   CLKS_PER_BIT cycles per bit. All outputs are registered.
//
//   Parameters:
//     CLKS_PER_BIT  sysclk cycles per UART bit (>= 2)
//     CNT_W         bit-period counter width, 2**CNT_W > CLKS_PER_BIT-1
//
//   Ports:
//     sysclk  system clock, rising edge
//     reset   asynchronous, active-high reset
//     bus     slave side of uart_transmitter_if
//             (tx_start, tx_data in; UART_TX, tx_busy, tx_done out)
// ---------------------------------------------------------------------------
module uart_transmitter #(
    parameter int CLKS_PER_BIT = 10417,
    parameter int CNT_W        = 14
) (
    input  logic               sysclk,
    input  logic               reset,
    uart_transmitter_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    state_t           r_state;
    logic [CNT_W-1:0] r_clk_cnt;
    logic [2:0]       r_bit_idx;
    logic [7:0]       r_shift;
    logic             r_tx;
    logic             r_busy;
    logic             r_done;

    logic             w_bit_end;

    // Last cycle of the current bit period; every state transition happens
    // on the edge that ends it.
    assign w_bit_end = (r_clk_cnt == CNT_LAST);

    // NOTE: all state lives in this one clocked block and uses non-blocking
    // assignments, so every register sees the pre-edge value of the others.
    always_ff @(posedge sysclk or posedge reset) begin
        if (reset) begin
            r_state   <= IDLE;
            r_clk_cnt <= '0;
            r_bit_idx <= '0;
            r_shift   <= '0;
            r_tx      <= 1'b1;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            // tx_done is a strobe: only the STOP->IDLE edge raises it.
            r_done <= 1'b0;

            case (r_state)
                IDLE: begin
                    r_tx      <= 1'b1;
                    r_clk_cnt <= '0;
                    if (bus.tx_start) begin
                        // Start bit goes out on the accepting edge itself.
                        r_shift   <= bus.tx_data;
                        r_bit_idx <= '0;
                        r_state   <= START;
                        r_busy    <= 1'b1;
                        r_tx      <= 1'b0;
                    end
                end

                START: begin
                    if (w_bit_end) begin
                        r_clk_cnt <= '0;
                        r_state   <= DATA;
                        r_tx      <= r_shift[0];
                    end else begin
                        r_clk_cnt <= r_clk_cnt + CNT_ONE;
                    end
                end

                DATA: begin
                    if (w_bit_end) begin
                        r_clk_cnt <= '0;
                        r_shift   <= {1'b0, r_shift[7:1]};
                        r_bit_idx <= r_bit_idx + 3'd1;
                        if (r_bit_idx == 3'd7) begin
                            r_state <= STOP;
                            r_tx    <= 1'b1;
                        end else begin
                            // Line is registered, so present the bit that
                            // becomes shift[0] after this edge.
                            r_tx <= r_shift[1];
                        end
                    end else begin
                        r_clk_cnt <= r_clk_cnt + CNT_ONE;
                    end
                end

                STOP: begin
                    if (w_bit_end) begin
                        r_clk_cnt <= '0;
                        r_state   <= IDLE;
                        r_busy    <= 1'b0;
                        r_done    <= 1'b1;
                    end else begin
                        r_clk_cnt <= r_clk_cnt + CNT_ONE;
                    end
                end

                default: begin
                    r_state <= IDLE;
                    r_tx    <= 1'b1;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.UART_TX = r_tx;
    assign bus.tx_busy = r_busy;
    assign bus.tx_done = r_done;

endmodule
